// File: rtl/load_store_unit.sv
// RV64 load/store sequencer for a doubleword-only data memory.
// Sub-doubleword stores use read-modify-write; bad requests get an error response.
module load_store_unit #(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_address,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_error,
  output logic [63:0] mem_address,
  output logic [63:0] mem_write_data,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [63:0] mem_read_data
);
  localparam logic [63:0] LAST = 64'(MEM_BYTES - 8);

  typedef enum logic [2:0] {
    IDLE, LOAD, RMW_READ, RMW_WRITE, WRITE, RESP
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  f3_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] merged_q;
  logic [63:0] rdata_q;
  logic        err_q;
  logic        accept;
  logic        bad;
  logic [63:0] load_ext;
  logic [63:0] merge_val;

  assign accept = req_valid && req_ready;
  assign bad = (req_address > LAST)
            || (!req_store && req_funct3 == 3'b111)
            || (req_store && req_funct3[2]);

  assign resp_data  = (state == RESP) ? rdata_q : 64'd0;
  assign resp_error = (state == RESP) && err_q;

  // Size and sign handling of the loaded doubleword.
  always_comb begin
    load_ext = mem_read_data;
    unique case (f3_q)
      3'b000:  load_ext = {{56{mem_read_data[7]}}, mem_read_data[7:0]};
      3'b001:  load_ext = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010:  load_ext = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
      3'b100:  load_ext = {56'd0, mem_read_data[7:0]};
      3'b101:  load_ext = {48'd0, mem_read_data[15:0]};
      3'b110:  load_ext = {32'd0, mem_read_data[31:0]};
      default: load_ext = mem_read_data;
    endcase
  end

  // Splice store bytes into the doubleword read back from memory.
  always_comb begin
    merge_val = wdata_q;
    unique case (f3_q[1:0])
      2'b00:   merge_val = {mem_read_data[63:8], wdata_q[7:0]};
      2'b01:   merge_val = {mem_read_data[63:16], wdata_q[15:0]};
      2'b10:   merge_val = {mem_read_data[63:32], wdata_q[31:0]};
      default: merge_val = wdata_q;
    endcase
  end

  // Next state and memory/handshake outputs; reset masks memory strobes.
  always_comb begin
    state_nx       = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = 64'd0;
    mem_write_data = 64'd0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (bad)                      state_nx = RESP;
          else if (!req_store)          state_nx = LOAD;
          else if (req_funct3 == 3'b011) state_nx = WRITE;
          else                          state_nx = RMW_READ;
        end
      end
      LOAD: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        state_nx    = RESP;
      end
      RMW_READ: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        state_nx    = RMW_WRITE;
      end
      RMW_WRITE: begin
        mem_write      = 1'b1;
        mem_address    = addr_q;
        mem_write_data = merged_q;
        state_nx       = RESP;
      end
      WRITE: begin
        mem_write      = 1'b1;
        mem_address    = addr_q;
        mem_write_data = wdata_q;
        state_nx       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (reset) begin
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = 64'd0;
      mem_write_data = 64'd0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Request latch, load result capture and RMW merge register.
  always_ff @(posedge clk) begin
    if (reset) begin
      f3_q     <= 3'd0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      merged_q <= 64'd0;
      rdata_q  <= 64'd0;
      err_q    <= 1'b0;
    end else begin
      if (accept) begin
        f3_q    <= req_funct3;
        addr_q  <= req_address;
        wdata_q <= req_wdata;
        rdata_q <= 64'd0;
        err_q   <= bad;
      end
      if (state == LOAD)     rdata_q  <= load_ext;
      if (state == RMW_READ) merged_q <= merge_val;
    end
  end
endmodule
